// File: rtl/barrel_rotl_pipe.sv
// Pipelined left-rotate barrel shifter: one 2^k rotate stage per magnitude bit,
// valid/ready on both sides, with a combinational enable chain that lets bubbles collapse.
module barrel_rotl_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_mag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
);

    localparam int SHIFT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] rotl_pow2(input logic [WIDTH-1:0] w, input int k);
        int amt;
        amt = 1 << k;
        return (w << amt) | (w >> (WIDTH - amt));
    endfunction

    logic [SHIFT_W-1:0][WIDTH-1:0]   data_q, data_d;
    logic [SHIFT_W-1:0][SHIFT_W-1:0] mag_q;
    logic [SHIFT_W-1:0]              valid_q;

    logic [SHIFT_W-1:0][WIDTH-1:0]   up_data;
    logic [SHIFT_W-1:0][SHIFT_W-1:0] up_mag;
    logic [SHIFT_W-1:0]              up_valid;
    logic [SHIFT_W:0]                en;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        en       = '0;
        up_data  = '0;
        up_mag   = '0;
        up_valid = '0;
        data_d   = '0;

        // A stage may load when it is empty or when the stage after it is moving.
        en[SHIFT_W] = out_ready;
        for (int k = SHIFT_W - 1; k >= 0; k--) begin
            en[k] = !valid_q[k] || en[k+1];
        end

        up_data[0]  = in_data;
        up_mag[0]   = in_mag;
        up_valid[0] = in_valid;
        for (int k = 1; k < SHIFT_W; k++) begin
            up_data[k]  = data_q[k-1];
            up_mag[k]   = mag_q[k-1];
            up_valid[k] = valid_q[k-1];
        end

        for (int k = 0; k < SHIFT_W; k++) begin
            data_d[k] = up_mag[k][k] ? rotl_pow2(up_data[k], k) : up_data[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its upstream's pre-edge value; the data registers are reset too because
    // out_data must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            mag_q   <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < SHIFT_W; k++) begin
                if (en[k]) begin
                    valid_q[k] <= up_valid[k];
                    // Payload only moves with a real word, so idle inputs never disturb it.
                    if (up_valid[k]) begin
                        data_q[k] <= data_d[k];
                        mag_q[k]  <= up_mag[k];
                    end
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = valid_q[SHIFT_W-1];
    assign out_data  = data_q[SHIFT_W-1];

endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Self-checking bench for barrel_rotl_pipe: randomized and directed traffic
// compared against a queue-based rotate-left reference model.
module tb_barrel_rotl_pipe;

    localparam int WIDTH   = 8;
    localparam int SHIFT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_mag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    barrel_rotl_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               acc;
    } entry_t;

    entry_t           sb_q[$];
    logic [WIDTH-1:0] obs_q[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    bit               last_in_fire = 1'b0;

    function automatic logic [WIDTH-1:0] rotl_ref(input int d, input int m);
        return WIDTH'(((d << m) | (d >> (WIDTH - m))) & 255);
    endfunction

    function automatic logic [WIDTH-1:0] rotr_ref(input int d, input int m);
        return WIDTH'(((d >> m) | (d << (WIDTH - m))) & 255);
    endfunction

    // One clock: compare outputs to the model at the falling edge, then
    // apply the transfers the model predicts at the rising edge.
    task automatic tick();
        bit               exp_ready, exp_valid, in_fire, out_fire;
        logic [WIDTH-1:0] seen_data;
        @(negedge clk);
        exp_ready = !(sb_q.size() == SHIFT_W && !out_ready);
        exp_valid = (sb_q.size() > 0) && ((cyc - sb_q[0].acc) >= SHIFT_W - 1);
        checks++;
        if (in_ready !== exp_ready) begin
            failures++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
        end
        checks++;
        if (out_valid !== exp_valid) begin
            failures++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (out_data !== sb_q[0].exp) begin
                failures++;
                $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, sb_q[0].exp);
            end
        end
        if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_data, prev_data);
            end
        end
        in_fire    = (in_valid === 1'b1) && (in_ready === 1'b1);
        out_fire   = (out_valid === 1'b1) && (out_ready === 1'b1);
        seen_data  = out_data;
        prev_stall = (out_valid === 1'b1) && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        cyc++;
        if (out_fire) begin
            obs_q.push_back(seen_data);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        if (in_fire) sb_q.push_back('{rotl_ref(int'(in_data), int'(in_mag)), cyc});
        last_in_fire = in_fire;
        #1;
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && sb_q.size() > 0; i++) tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mag    = '0;
        out_ready = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got=%b/%h/%b exp=0/00/1", out_valid, out_data, in_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] td[5] = '{8'h81, 8'hA5, 8'h01, 8'h3C, 8'h96};
        logic [2:0] tm[5] = '{3'd1, 3'd4, 3'd7, 3'd0, 3'd3};
        logic [7:0] te[5] = '{8'h03, 8'h5A, 8'h80, 8'h3C, 8'hB4};
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = td[i];
            in_mag    = tm[i];
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== te[i]) begin
                failures++;
                $display("FAIL single_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, te[i]);
            end
            tick();
        end
    endtask

    task automatic test_stream();
        int n_in = 0;
        obs_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_mag   = 3'(i % 8);
            tick();
            if (last_in_fire) n_in++;
        end
        drain(8);
        checks++;
        if (n_in != 256 || obs_q.size() != 256) begin
            failures++;
            $display("FAIL stream_count got=%0d/%0d exp=256/256", n_in, obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words[3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] want[3]  = '{8'h22, 8'h44, 8'h66};
        obs_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            in_mag   = 3'd1;
            tick();
        end
        in_data = 8'h44;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_data !== 8'h22) begin
                failures++;
                $display("FAIL bp_full got=%b/%h exp=0/22", in_ready, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got=%b exp=1", in_ready);
        end
        tick();
        drain(8);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q.size() <= i || obs_q[i] !== want[i]) begin
                failures++;
                $display("FAIL bp_order_%0d got=%h exp=%h", i, (obs_q.size() > i) ? obs_q[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [7:0] orig[$];
        obs_q.delete();
        out_ready = 1'b1;
        for (int d = 0; d < 256; d++) begin
            for (int m = 0; m < 8; m++) begin
                in_valid = 1'b1;
                in_data  = rotr_ref(d, m);
                in_mag   = 3'(m);
                orig.push_back(8'(d));
                tick();
            end
        end
        drain(8);
        checks++;
        if (obs_q.size() != orig.size()) begin
            failures++;
            $display("FAIL round_trip_count got=%0d exp=%0d", obs_q.size(), orig.size());
        end
        for (int i = 0; i < orig.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== orig[i]) begin
                failures++;
                $display("FAIL round_trip_%0d got=%h exp=%h", i, obs_q[i], orig[i]);
            end
        end
    endtask

    task automatic test_random();
        int n_acc = 0;
        obs_q.delete();
        in_valid = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (!in_valid || last_in_fire) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                in_mag   = 3'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_in_fire) n_acc++;
        end
        drain(16);
        checks++;
        if (obs_q.size() != n_acc) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), n_acc);
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + i);
            in_mag   = 3'd5;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%b/%h/%b exp=0/00/1", out_valid, out_data, in_ready);
        end
        sb_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_flush got=%0d words exp=0", obs_q.size());
        end
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_mag   = 3'd2;
        tick();
        in_valid = 1'b0;
        drain(8);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 8'h0F) begin
            failures++;
            $display("FAIL reset_next got=%0d/%h exp=1/0f", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_round_trip();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
